// File: rtl/div_ctrl.sv
// div_ctrl: sequences signed/unsigned divide and remainder requests onto an unsigned iterative divider.
// Optional DIV_EARLY_OUT_EN: zero-divisor, overflow and |a|<|b| requests bypass the divider.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic              in_rem,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              flush,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              div_en,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  input  logic              div_end
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  state_t            state_q;
  logic              rem_q, sign_a_q, sign_b_q, zero_b_q, ovf_q;
  logic              div_en_q, out_valid_q;
  logic [DATA_W-1:0] a_q, dividend_q, divisor_q, out_data_q;
  logic              sign_a_d, sign_b_d, zero_b_d, ovf_d, early_d;
  logic [DATA_W-1:0] mag_a_d, mag_b_d;
  assign sign_a_d = in_signed & in_a[DATA_W-1];
  assign sign_b_d = in_signed & in_b[DATA_W-1];
  assign zero_b_d = in_b == '0;
  assign ovf_d    = in_signed & (in_a == MIN_NEG) & (in_b == '1);
  assign mag_a_d  = sign_a_d ? -in_a : in_a;
  assign mag_b_d  = sign_b_d ? -in_b : in_b;
`ifdef DIV_EARLY_OUT_EN
  assign early_d = zero_b_d | ovf_d | (mag_a_d < mag_b_d);
`else
  assign early_d = 1'b0;
`endif
  // Sign fix-up; the divider works on magnitudes so special cases override its output.
  function automatic logic [DATA_W-1:0] result(input logic rem, zb, ov, sa, sb,
                                               input logic [DATA_W-1:0] a, q, r);
    logic [DATA_W-1:0] qq, rr;
    qq = zb ? '1 : ov ? MIN_NEG : (sa ^ sb) ? -q : q;
    rr = zb ? a : ov ? '0 : sa ? -r : r;
    return rem ? rr : qq;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      zero_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
      div_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      out_data_q  <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      div_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          rem_q      <= in_rem;
          sign_a_q   <= sign_a_d;
          sign_b_q   <= sign_b_d;
          zero_b_q   <= zero_b_d;
          ovf_q      <= ovf_d;
          a_q        <= in_a;
          dividend_q <= mag_a_d;
          divisor_q  <= mag_b_d;
          if (early_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= result(in_rem, zero_b_d, ovf_d, sign_a_d, sign_b_d, in_a, '0, mag_a_d);
          end else begin
            state_q  <= RUN;
            div_en_q <= 1'b1;
          end
        end
        RUN: if (div_end) begin
          state_q     <= DONE;
          div_en_q    <= 1'b0;
          out_valid_q <= 1'b1;
          out_data_q  <= result(rem_q, zero_b_q, ovf_q, sign_a_q, sign_b_q, a_q,
                                div_quotient, div_remainder);
        end
        DONE: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready     = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign div_en       = div_en_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer between the EX stage and the unsigned iterative divider. Accepts a signed or unsigned divide/remainder request, converts operands to magnitudes and drives the divider's enable/operand ports. It waits for the divider's end flag, then applies sign correction and the zero-divisor/overflow rules. It returns one 32-bit result to EX with a valid pulse, holding EX stalled meanwhile.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request strobe from EX, sampled only when in_ready=1
- in_ready  out  1  high only in IDLE
- in_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU
- in_rem  in  1  1 = return remainder, 0 = quotient
- in_a  in  DATA_W  dividend
- in_b  in  DATA_W  divisor
- flush  in  1  abort current operation (pipeline flush)
- busy  out  1  high in RUN and DONE; EX stall source
- out_valid  out  1  one-cycle result strobe
- out_data  out  DATA_W  result, valid when out_valid=1
- div_en  out  1  divider enable
- div_dividend  out  DATA_W  registered dividend magnitude
- div_divisor  out  DATA_W  registered divisor magnitude
- div_quotient  in  DATA_W  divider quotient
- div_remainder  in  DATA_W  divider remainder
- div_end  in  1  divider completion flag

## Operation
- States: IDLE, RUN, DONE. Reset (rst_n low, any state): IDLE, busy=0, out_valid=0, out_data=0, div_en=0, div_dividend=0, div_divisor=0, all flags 0.
- IDLE: in_ready=1. in_valid=1 → register in_signed, in_rem, sign_a = in_signed&in_a[31], sign_b = in_signed&in_b[31], zero_b = (in_b==0), ovf = in_signed&(in_a==0x80000000)&(in_b==0xFFFFFFFF), magnitudes |a| and |b| (two's-complement negate when the sign flag is set; |0x80000000| = 0x80000000) into div_dividend/div_divisor → RUN.
- RUN: div_en=1. div_end=1 → capture div_quotient/div_remainder → DONE. Otherwise hold.
- DONE: div_en=0, out_valid=1 → IDLE.
- Result selection in DONE, in priority order:
  - zero_b: quotient 0xFFFFFFFF, remainder = original in_a.
  - ovf: quotient 0x80000000, remainder 0.
  - Otherwise: quotient negated if sign_a^sign_b; remainder negated if sign_a.
- out_data = remainder if in_rem, else quotient.
- flush has priority over every transition: next state IDLE, div_en=0, out_valid=0, captured request dropped. flush in IDLE together with in_valid → request not accepted.
- Operand outputs change only on an accept edge. They stay stable while div_en is low, so the divider loads them on its own disabled cycle.

## Timing
- Accept at edge E0. RUN starts at E0+1. Divider loads during the first RUN cycle (its registered enable is still low), then iterates.
- Total latency, accept to out_valid = D+2 cycles, where D = cycles from div_en rising to div_end.
- div_en is low for at least 2 consecutive cycles (DONE plus IDLE) between operations. This guarantees the divider counter resets.
- Back-to-back: a new in_valid is accepted in the IDLE cycle directly after DONE.
- out_valid is never high in the same cycle as in_ready.
- div_end outside RUN is ignored.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - zero_b, ovf, and unsigned-magnitude |a|<|b| requests skip RUN: IDLE → DONE directly, div_en never asserted, latency 1 cycle.
  - For |a|<|b|: quotient 0, remainder = in_a.
- Undefined: every request goes through RUN with uniform latency. zero_b/ovf results are substituted in DONE as above.

## Test plan
- Unsigned 100 ÷ 7, in_rem=0 then 1 → out_data 14, then 2. One out_valid pulse each, after D+2 cycles.
- Signed 0xFFFFFF9C ÷ 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 ÷ 0xFFFFFFF9 → quotient 0xFFFFFFF2, remainder 2.
- Divide by zero, signed 0xFFFFFFFB ÷ 0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFB. With DIV_EARLY_OUT_EN: result 1 cycle after accept, div_en stays 0.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- flush asserted 5 cycles into RUN → next cycle IDLE, div_en=0, no out_valid. A following 9 ÷ 3 request returns 3 correctly.
- Two back-to-back requests (20÷6, then 21÷6): second accepted in the IDLE cycle after the first DONE. Results 3 then 3, remainders 2 then 3. div_en low for exactly 2 cycles between them.
- rst_n pulsed low mid-RUN → all outputs 0 immediately, in_ready=1 after release.
